mci_control_fsm: RTL
====================

Name: mci_control_fsm

Overview:
- Multi-cycle control unit that sequences the shared register-file/ALU datapath, one instruction at a time, through fetch/decode/execute/memory/writeback steps.
- Decodes the 6-bit opcode from the instruction register and drives the datapath enables and mux selects for each step.
- Produces the ALU op class and a gated PC enable using the ALU zero flag.
- Also counts retired instructions, supports run/stop, and traps on illegal opcodes.

Parameters:
- CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = execute instructions; 0 = stop at next instruction boundary
- opcode  in  6  IR[31:26]; valid from DECODE onward
- zero  in  1  ALU zero flag, combinational from the datapath
- pc_en  out  1  PCWrite | (PCWriteCond & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal  out  1  high while in TRAP
- busy  out  1  high in every state except IDLE and TRAP
- state  out  4  current state encoding, for debug
- instr_count  out  CNT_W  retired instructions

Behaviour:
- State encoding: IDLE=14, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, TRAP=15. Encodings 12 and 13 are unused and go to TRAP.
- Reset: while rst_n=0, state=IDLE and instr_count=0. All outputs are a Moore decode of state, so every enable and select is 0 during and immediately after reset.
- Per-state outputs (anything not listed is 0):
  - FETCH: mem_read, ir_write, alu_src_b=01, pc_en=1.
  - DECODE: alu_src_b=11.
  - MEMADR, ADDI_EX: alu_src_a=1, alu_src_b=10.
  - MEMRD: mem_read, iord.
  - MEMWB: reg_write, mem_to_reg.
  - MEMWR: mem_write, iord.
  - EXEC: alu_src_a=1, alu_op=10.
  - RWB: reg_write, reg_dst.
  - BRANCH: alu_src_a=1, alu_op=01, PCWriteCond=1, pc_source=01, so pc_en=zero.
  - JUMP: pc_en=1, pc_source=10.
  - ADDI_WB: reg_write.
- Transitions:
  - IDLE -> FETCH when run=1, otherwise stay in IDLE.
  - FETCH -> DECODE.
  - DECODE by opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EX; any other opcode -> TRAP.
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB. EXEC -> RWB. ADDI_EX -> ADDI_WB.
  - TRAP holds until reset; run is ignored.
- Final states (MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDI_WB):
  - Increment instr_count on the exit edge.
  - Next state is FETCH if run=1, otherwise IDLE.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- run is sampled only in IDLE and in final states. Deasserting run mid-instruction lets that instruction complete.
- Illegal opcode:
  - Entering TRAP does not increment instr_count.
  - opcode is ignored outside DECODE and MEMADR.
- instr_count wraps from 2^CNT_W-1 to 0 with no flag.
- Asynchronous reset in any state (including mid-writeback or TRAP) returns to IDLE immediately, with outputs 0 in the same cycle.

Test Plan:
- Reset with run=1; release rst_n -> state 14 then 0; only FETCH enables active; first DECODE on the 2nd edge after release.
- lw (opcode 100011) -> states 0,1,2,3,4,0 visited; reg_write=1 and mem_to_reg=1 only in cycle 5; instr_count 0→1.
- beq (opcode 000100): zero=1 -> pc_en=1 in BRANCH; repeat with zero=0 -> pc_en=0; 3 cycles each; count increments both times.
- Opcode 111111 at DECODE -> TRAP; illegal=1, busy=0, instr_count unchanged. Toggling run has no effect; rst_n pulse -> IDLE.
- run dropped during EXEC of an R-type -> RWB completes with reg_write=1, then IDLE with busy=0; run=1 resumes at FETCH.
- CNT_W=4, 16 back-to-back j instructions -> instr_count goes 15→0. Async reset asserted mid-MEMRD -> state=14 and mem_read=0 before the next clk edge.

Source files
------------

// File: rtl/mci_control_fsm.sv
// Multi-cycle instruction control unit: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and selects as a Moore decode of state, counts retired instructions.
module mci_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic             busy,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH  = 4'd8,  S_JUMP    = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_IDLE    = 4'd14, S_TRAP    = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t cur, nxt;
  logic   retire;
  logic   pc_write, pc_write_cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // Final states retire the instruction and choose between the next fetch and IDLE.
  always_comb begin
    nxt    = cur;
    retire = 1'b0;
    case (cur)
      S_IDLE:   nxt = run ? S_FETCH : S_IDLE;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYP:      nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDIEX;
          default:      nxt = S_TRAP;
        endcase
      end
      S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = S_MEMWB;
      S_EXEC:   nxt = S_RWB;
      S_ADDIEX: nxt = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        retire = 1'b1;
        nxt    = run ? S_FETCH : S_IDLE;
      end
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_TRAP;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    busy          = 1'b1;
    case (cur)
      S_IDLE:   busy = 1'b0;
      S_TRAP:   begin illegal = 1'b1; busy = 1'b0; end
      S_FETCH:  begin mem_read = 1'b1; ir_write = 1'b1; alu_src_b = 2'b01; pc_write = 1'b1; end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEMRD:  begin mem_read = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_MEMWR:  begin mem_write = 1'b1; iord = 1'b1; end
      S_EXEC:   begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_RWB:    begin reg_write = 1'b1; reg_dst = 1'b1; end
      S_BRANCH: begin alu_src_a = 1'b1; alu_op = 2'b01; pc_write_cond = 1'b1; pc_source = 2'b01; end
      S_JUMP:   begin pc_write = 1'b1; pc_source = 2'b10; end
      S_ADDIWB: reg_write = 1'b1;
      default:  ;
    endcase
  end

  assign pc_en = pc_write | (pc_write_cond & zero);
  assign state = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

endmodule
